// File: rtl/wb_bram_ctrl_if.sv
// wb_bram_ctrl_if -- bundles the Wishbone slave port and the BRAM port-0 signals of
// wb_bram_ctrl.
//
//   wbs_stb_i, wbs_cyc_i, wbs_we_i : Wishbone strobe, cycle, write enable
//   wbs_sel_i  [3:0]               : byte lanes
//   wbs_dat_i  [31:0]              : write data
//   wbs_adr_i  [31:0]              : byte address
//   wbs_ack_o                      : one-cycle acknowledge
//   wbs_dat_o  [31:0]              : read data (zero when not acking a read)
//   bram_en_o                      : BRAM enable
//   bram_we_o  [3:0]               : BRAM byte write enables
//   bram_adr_o [31:0]              : BRAM byte address
//   bram_dat_o [31:0]              : BRAM write data
//   bram_dat_i [31:0]              : BRAM read data, valid one cycle after the address
//
// The slave modport is the controller side; the master modport is the bus master plus
// the BRAM model.
interface wb_bram_ctrl_if;
    logic        wbs_stb_i;
    logic        wbs_cyc_i;
    logic        wbs_we_i;
    logic [3:0]  wbs_sel_i;
    logic [31:0] wbs_dat_i;
    logic [31:0] wbs_adr_i;
    logic        wbs_ack_o;
    logic [31:0] wbs_dat_o;
    logic        bram_en_o;
    logic [3:0]  bram_we_o;
    logic [31:0] bram_adr_o;
    logic [31:0] bram_dat_o;
    logic [31:0] bram_dat_i;

    modport slave (
        input  wbs_stb_i, wbs_cyc_i, wbs_we_i, wbs_sel_i, wbs_dat_i, wbs_adr_i, bram_dat_i,
        output wbs_ack_o, wbs_dat_o, bram_en_o, bram_we_o, bram_adr_o, bram_dat_o
    );

    modport master (
        output wbs_stb_i, wbs_cyc_i, wbs_we_i, wbs_sel_i, wbs_dat_i, wbs_adr_i, bram_dat_i,
        input  wbs_ack_o, wbs_dat_o, bram_en_o, bram_we_o, bram_adr_o, bram_dat_o
    );
endinterface

// File: rtl/wb_bram_ctrl.sv
// wb_bram_ctrl -- Wishbone slave in front of a BRAM, with a single 4-word line buffer.
//
// Read hits are served from the line buffer in two cycles. Read misses refill the whole
// 16-byte line from BRAM and writes go straight through to BRAM (merging into the line on
// a hit); both are acknowledged a fixed LATENCY cycles after acceptance.
//
// Ports:
//   wb_clk_i : clock, rising edge
//   wb_rst_i : asynchronous, active-high reset
//   inval_i  : single-cycle pulse, invalidates the line buffer
//   bus      : Wishbone slave + BRAM port-0 signals (wb_bram_ctrl_if.slave)
//
// Parameters:
//   BASE    : Wishbone window, compared with wbs_adr_i[31:20]
//   LATENCY : cycles from acceptance to ack for misses and writes (6..15)
module wb_bram_ctrl #(
    parameter logic [11:0] BASE    = 12'h380,
    parameter int unsigned LATENCY = 10
) (
    input  logic          wb_clk_i,
    input  logic          wb_rst_i,
    input  logic          inval_i,
    wb_bram_ctrl_if.slave bus
);

    // WAIT leaves on the edge where the counter reads LATENCY-1, so ack rises exactly
    // LATENCY edges after acceptance.
    localparam logic [3:0] LatLast  = 4'(LATENCY - 1);
    localparam logic [3:0] FillLast = 4'd4;

    typedef enum logic [2:0] {
        StIdle,
        StHit,
        StFill,
        StWr,
        StWait,
        StAck
    } state_e;

    state_e state_q, state_d;

    // Latched request.
    logic [31:0] adr_q;
    logic        we_q;
    logic [3:0]  sel_q;
    logic [31:0] dat_q;

    logic [3:0]  cnt_q, cnt_d;
    logic        line_valid_q, line_valid_d;
    logic        abort_q, abort_d;          // cyc dropped: finish quietly, no ack
    logic        fill_inval_q, fill_inval_d; // inval seen during the current fill

    logic [27:0] tag_q;
    logic [31:0] buf_q [4];

    logic        accept;
    logic        req_hit;
    logic        fill_issue;
    logic        fill_cap;
    logic        fill_last;
    logic        wr_merge;

    logic        buf_we;
    logic [1:0]  buf_idx;
    logic [31:0] buf_wdata;

    assign accept  = (state_q == StIdle) && bus.wbs_cyc_i && bus.wbs_stb_i &&
                     (bus.wbs_adr_i[31:20] == BASE);
    assign req_hit = line_valid_q && (tag_q == bus.wbs_adr_i[31:4]);

    // Fill: addresses issued while cnt is 0..3, data captured one cycle later (cnt 1..4).
    assign fill_issue = (state_q == StFill) && (cnt_q < FillLast);
    assign fill_cap   = (state_q == StFill) && (cnt_q != 4'd0);
    assign fill_last  = (state_q == StFill) && (cnt_q == FillLast);
    assign wr_merge   = (state_q == StWr) && line_valid_q && (tag_q == adr_q[31:4]) &&
                        !inval_i;

    // ---------------------------------------------------------------- state register
    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // ---------------------------------------------------------------- next state
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle: begin
                if (accept) begin
                    if (bus.wbs_we_i) begin
                        state_d = StWr;
                    end else if (req_hit) begin
                        state_d = StHit;
                    end else begin
                        state_d = StFill;
                    end
                end
            end
            StHit:  state_d = StAck;
            StFill: if (fill_last) state_d = StWait;
            StWr:   state_d = StWait;
            StWait: if (cnt_q == LatLast) state_d = StAck;
            StAck:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    // ---------------------------------------------------------------- outputs
    always_comb begin
        bus.wbs_ack_o  = 1'b0;
        bus.wbs_dat_o  = 32'h0;
        bus.bram_en_o  = 1'b0;
        bus.bram_we_o  = 4'h0;
        bus.bram_adr_o = 32'h0;
        bus.bram_dat_o = 32'h0;
        unique case (state_q)
            StFill: begin
                if (fill_issue) begin
                    bus.bram_en_o  = 1'b1;
                    bus.bram_adr_o = {adr_q[31:4], cnt_q[1:0], 2'b00};
                end
            end
            StWr: begin
                bus.bram_en_o  = 1'b1;
                bus.bram_we_o  = sel_q;
                bus.bram_adr_o = adr_q;
                bus.bram_dat_o = dat_q;
            end
            StAck: begin
                if (!abort_q) begin
                    bus.wbs_ack_o = 1'b1;
                    if (!we_q) begin
                        bus.wbs_dat_o = buf_q[adr_q[3:2]];
                    end
                end
            end
            default: ;
        endcase
    end

    // ---------------------------------------------------------------- control regs
    always_comb begin
        cnt_d = cnt_q;
        if (accept) begin
            cnt_d = 4'd0;
        end else if (state_q != StIdle) begin
            cnt_d = cnt_q + 4'd1;
        end
    end

    always_comb begin
        abort_d = abort_q;
        if (accept) begin
            abort_d = 1'b0;
        end else if ((state_q != StIdle) && (state_q != StAck) && !bus.wbs_cyc_i) begin
            abort_d = 1'b1;
        end
    end

    always_comb begin
        fill_inval_d = fill_inval_q;
        if (accept) begin
            fill_inval_d = 1'b0;
        end else if ((state_q == StFill) && inval_i) begin
            fill_inval_d = 1'b1;
        end
    end

    // inval_i has the last word, including over a same-cycle fill completion.
    always_comb begin
        line_valid_d = line_valid_q;
        if (fill_last) begin
            line_valid_d = !fill_inval_q;
        end
        if (inval_i) begin
            line_valid_d = 1'b0;
        end
    end

    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            cnt_q        <= 4'd0;
            line_valid_q <= 1'b0;
            abort_q      <= 1'b0;
            fill_inval_q <= 1'b0;
        end else begin
            cnt_q        <= cnt_d;
            line_valid_q <= line_valid_d;
            abort_q      <= abort_d;
            fill_inval_q <= fill_inval_d;
        end
    end

    // ---------------------------------------------------------------- datapath
    // Buffer write port: a fill capture or a byte-merged write hit (never both at once).
    always_comb begin
        buf_we    = 1'b0;
        buf_idx   = adr_q[3:2];
        buf_wdata = buf_q[adr_q[3:2]];
        if (fill_cap) begin
            buf_we    = 1'b1;
            buf_idx   = 2'(cnt_q - 4'd1);
            buf_wdata = bus.bram_dat_i;
        end else if (wr_merge) begin
            buf_we = 1'b1;
            for (int b = 0; b < 4; b++) begin
                if (sel_q[b]) begin
                    buf_wdata[8*b +: 8] = dat_q[8*b +: 8];
                end
            end
        end
    end

    // Request, tag and line data need no reset: line_valid_q and the FSM gate all use.
    always_ff @(posedge wb_clk_i) begin
        if (accept) begin
            adr_q <= bus.wbs_adr_i;
            we_q  <= bus.wbs_we_i;
            sel_q <= bus.wbs_sel_i;
            dat_q <= bus.wbs_dat_i;
        end
        if (fill_last) begin
            tag_q <= adr_q[31:4];
        end
        if (buf_we) begin
            buf_q[buf_idx] <= buf_wdata;
        end
    end

endmodule

// File: tb/tb_wb_bram_ctrl.sv
// Directed bench for wb_bram_ctrl (BASE=12'h380, LATENCY=10) with a small BRAM model.
module tb_wb_bram_ctrl;

    localparam logic [31:0] WA = 32'h1111_AAAA, WB = 32'h2222_BBBB;
    localparam logic [31:0] WC = 32'h3333_CCCC, WD = 32'h4444_DDDD;
    localparam logic [31:0] WE = 32'h5555_EEEE, WF = 32'h6666_FFFF;
    localparam logic [31:0] WG = 32'h7777_0123, WH = 32'h8888_4567;
    localparam logic [31:0] WI = 32'hC0DE_0000, WJ = 32'hC0DE_0004;
    localparam logic [31:0] WK = 32'hC0DE_0008, WL = 32'hC0DE_000C;

    logic clk = 1'b0;
    logic rst;
    logic inval;

    int errors = 0;
    int checks = 0;

    wb_bram_ctrl_if bus_if ();

    wb_bram_ctrl #(
        .BASE    (12'h380),
        .LATENCY (10)
    ) dut (
        .wb_clk_i (clk),
        .wb_rst_i (rst),
        .inval_i  (inval),
        .bus      (bus_if)
    );

    always #5 clk = ~clk;

    // BRAM model: byte address bits [5:2] select one of 16 words, read-first, 1-cycle read.
    logic [31:0] mem [16] = '{WI, WJ, WK, WL, WA, WB, WC, WD, WE, WF, WG, WH,
                              32'h0, 32'h0, 32'h0, 32'h0};
    logic [31:0] bram_rd = 32'h0;

    always @(posedge clk) begin
        if (bus_if.bram_en_o) begin
            for (int b = 0; b < 4; b++) begin
                if (bus_if.bram_we_o[b]) begin
                    mem[bus_if.bram_adr_o[5:2]][8*b +: 8] <= bus_if.bram_dat_o[8*b +: 8];
                end
            end
            bram_rd <= mem[bus_if.bram_adr_o[5:2]];
        end
    end
    assign bus_if.bram_dat_i = bram_rd;

    // Observations from the last transaction; index i = cycle after edge T0+i.
    int          obs_ack_idx;
    int          obs_ack_cnt;
    logic [31:0] obs_ack_dat;
    int          obs_en_cnt;
    int          obs_quiet_bad;
    int          obs_en_idx [8];
    logic [31:0] obs_en_adr [8];
    logic [31:0] obs_en_dat [8];
    logic [3:0]  obs_en_we  [8];

    // Drives one request, scrambles the bus after acceptance, and records what happens.
    task automatic run_txn(input logic we, input logic [31:0] adr, input logic [3:0] sel,
                           input logic [31:0] dat, input int ncyc, input int drop_at,
                           input int inval_at);
        obs_ack_idx   = -1;
        obs_ack_cnt   = 0;
        obs_ack_dat   = 32'h0;
        obs_en_cnt    = 0;
        obs_quiet_bad = 0;
        @(negedge clk);
        bus_if.wbs_cyc_i = 1'b1;
        bus_if.wbs_stb_i = 1'b1;
        bus_if.wbs_we_i  = we;
        bus_if.wbs_adr_i = adr;
        bus_if.wbs_sel_i = sel;
        bus_if.wbs_dat_i = dat;
        @(posedge clk);
        for (int i = 0; i < ncyc; i++) begin
            @(negedge clk);
            if (i == 0) begin
                bus_if.wbs_adr_i = {adr[31:20], ~adr[19:0]};
                bus_if.wbs_sel_i = ~sel;
                bus_if.wbs_dat_i = ~dat;
            end
            if (i == drop_at) begin
                bus_if.wbs_cyc_i = 1'b0;
                bus_if.wbs_stb_i = 1'b0;
            end
            inval = (i == inval_at);
            if (bus_if.wbs_ack_o) begin
                if (obs_ack_idx < 0) begin
                    obs_ack_idx = i;
                    obs_ack_dat = bus_if.wbs_dat_o;
                end
                obs_ack_cnt++;
                bus_if.wbs_cyc_i = 1'b0;
                bus_if.wbs_stb_i = 1'b0;
            end else if (bus_if.wbs_dat_o !== 32'h0) begin
                obs_quiet_bad++;
            end
            if (bus_if.bram_en_o) begin
                if (obs_en_cnt < 8) begin
                    obs_en_idx[obs_en_cnt] = i;
                    obs_en_adr[obs_en_cnt] = bus_if.bram_adr_o;
                    obs_en_dat[obs_en_cnt] = bus_if.bram_dat_o;
                    obs_en_we[obs_en_cnt]  = bus_if.bram_we_o;
                end
                obs_en_cnt++;
            end else if ((bus_if.bram_we_o !== 4'h0) || (bus_if.bram_adr_o !== 32'h0) ||
                         (bus_if.bram_dat_o !== 32'h0)) begin
                obs_quiet_bad++;
            end
        end
        inval = 1'b0;
        bus_if.wbs_cyc_i = 1'b0;
        bus_if.wbs_stb_i = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        inval = 1'b0;
        bus_if.wbs_cyc_i = 1'b0;
        bus_if.wbs_stb_i = 1'b0;
        bus_if.wbs_we_i  = 1'b0;
        bus_if.wbs_sel_i = 4'h0;
        bus_if.wbs_dat_i = 32'h0;
        bus_if.wbs_adr_i = 32'h0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checks++;
        if (bus_if.wbs_ack_o !== 1'b0) begin
            errors++; $display("FAIL reset_ack: got %b expected 0", bus_if.wbs_ack_o);
        end
        checks++;
        if (bus_if.wbs_dat_o !== 32'h0) begin
            errors++; $display("FAIL reset_dat: got %h expected 0", bus_if.wbs_dat_o);
        end
        checks++;
        if (bus_if.bram_en_o !== 1'b0) begin
            errors++; $display("FAIL reset_en: got %b expected 0", bus_if.bram_en_o);
        end
        checks++;
        if ({bus_if.bram_we_o, bus_if.bram_adr_o, bus_if.bram_dat_o} !== 68'h0) begin
            errors++;
            $display("FAIL reset_bram: got we=%h adr=%h dat=%h expected all 0",
                     bus_if.bram_we_o, bus_if.bram_adr_o, bus_if.bram_dat_o);
        end
        rst = 1'b0;
        repeat (2) @(negedge clk);
        checks++;
        if ((bus_if.wbs_ack_o !== 1'b0) || (bus_if.bram_en_o !== 1'b0)) begin
            errors++;
            $display("FAIL post_reset_idle: got ack=%b en=%b expected 0 0",
                     bus_if.wbs_ack_o, bus_if.bram_en_o);
        end
    endtask

    task automatic test_reset_mid();
        int acks;
        int ens;
        acks = 0;
        ens  = 0;
        @(negedge clk);
        bus_if.wbs_cyc_i = 1'b1;
        bus_if.wbs_stb_i = 1'b1;
        bus_if.wbs_we_i  = 1'b0;
        bus_if.wbs_adr_i = 32'h3800_0000;
        @(posedge clk);
        repeat (3) @(negedge clk);
        checks++;
        if (bus_if.bram_en_o !== 1'b1) begin
            errors++; $display("FAIL mid_fill_en: got %b expected 1", bus_if.bram_en_o);
        end
        rst = 1'b1;
        bus_if.wbs_cyc_i = 1'b0;
        bus_if.wbs_stb_i = 1'b0;
        #1;
        checks++;
        if (bus_if.bram_en_o !== 1'b0) begin
            errors++; $display("FAIL async_reset_en: got %b expected 0", bus_if.bram_en_o);
        end
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 15; i++) begin
            @(negedge clk);
            if (bus_if.wbs_ack_o) acks++;
            if (bus_if.bram_en_o) ens++;
        end
        checks++;
        if ((acks != 0) || (ens != 0)) begin
            errors++;
            $display("FAIL reset_mid_drop: got acks=%0d bram_en=%0d expected 0 0", acks, ens);
        end
    endtask

    task automatic test_cold_read();
        run_txn(1'b0, 32'h3800_0014, 4'hF, 32'h0, 16, -1, -1);
        checks++;
        if (obs_en_cnt != 4) begin
            errors++; $display("FAIL cold_nreads: got %0d expected 4", obs_en_cnt);
        end
        for (int k = 0; k < 4; k++) begin
            checks++;
            if ((obs_en_idx[k] != k) || (obs_en_adr[k] !== 32'h3800_0010 + 32'(4 * k)) ||
                (obs_en_we[k] !== 4'h0)) begin
                errors++;
                $display("FAIL cold_read%0d: got cyc=%0d adr=%h we=%h expected %0d %h 0",
                         k, obs_en_idx[k], obs_en_adr[k], obs_en_we[k], k,
                         32'h3800_0010 + 32'(4 * k));
            end
        end
        checks++;
        if ((obs_ack_idx != 10) || (obs_ack_cnt != 1)) begin
            errors++;
            $display("FAIL cold_ack: got idx=%0d cnt=%0d expected 10 1",
                     obs_ack_idx, obs_ack_cnt);
        end
        checks++;
        if (obs_ack_dat !== WB) begin
            errors++; $display("FAIL cold_dat: got %h expected %h", obs_ack_dat, WB);
        end
        checks++;
        if (obs_quiet_bad != 0) begin
            errors++; $display("FAIL cold_quiet: got %0d expected 0", obs_quiet_bad);
        end
    endtask

    task automatic test_hit_read();
        run_txn(1'b0, 32'h3800_001C, 4'hF, 32'h0, 6, -1, -1);
        checks++;
        if ((obs_ack_idx != 1) || (obs_ack_cnt != 1) || (obs_en_cnt != 0)) begin
            errors++;
            $display("FAIL hit_timing: got idx=%0d acks=%0d reads=%0d expected 1 1 0",
                     obs_ack_idx, obs_ack_cnt, obs_en_cnt);
        end
        checks++;
        if (obs_ack_dat !== WD) begin
            errors++; $display("FAIL hit_dat: got %h expected %h", obs_ack_dat, WD);
        end
    endtask

    task automatic test_write();
        run_txn(1'b1, 32'h3800_0018, 4'b0011, 32'hFFFF_1234, 16, -1, -1);
        checks++;
        if ((obs_en_cnt != 1) || (obs_en_idx[0] != 0) || (obs_en_adr[0] !== 32'h3800_0018) ||
            (obs_en_we[0] !== 4'b0011) || (obs_en_dat[0] !== 32'hFFFF_1234)) begin
            errors++;
            $display("FAIL wr_bram: got n=%0d cyc=%0d adr=%h we=%h dat=%h expected 1 0 %h 3 %h",
                     obs_en_cnt, obs_en_idx[0], obs_en_adr[0], obs_en_we[0], obs_en_dat[0],
                     32'h3800_0018, 32'hFFFF_1234);
        end
        checks++;
        if ((obs_ack_idx != 10) || (obs_ack_cnt != 1) || (obs_ack_dat !== 32'h0)) begin
            errors++;
            $display("FAIL wr_ack: got idx=%0d cnt=%0d dat=%h expected 10 1 0",
                     obs_ack_idx, obs_ack_cnt, obs_ack_dat);
        end
        checks++;
        if (mem[6] !== 32'h3333_1234) begin
            errors++; $display("FAIL wr_mem: got %h expected %h", mem[6], 32'h3333_1234);
        end
        run_txn(1'b0, 32'h3800_0018, 4'hF, 32'h0, 6, -1, -1);
        checks++;
        if ((obs_ack_idx != 1) || (obs_en_cnt != 0) || (obs_ack_dat !== 32'h3333_1234)) begin
            errors++;
            $display("FAIL wr_merge_hit: got idx=%0d reads=%0d dat=%h expected 1 0 %h",
                     obs_ack_idx, obs_en_cnt, obs_ack_dat, 32'h3333_1234);
        end
    endtask

    task automatic test_inval();
        @(negedge clk);
        inval = 1'b1;
        @(negedge clk);
        inval = 1'b0;
        run_txn(1'b0, 32'h3800_0010, 4'hF, 32'h0, 16, -1, -1);
        checks++;
        if ((obs_en_cnt != 4) || (obs_ack_idx != 10) || (obs_ack_dat !== WA)) begin
            errors++;
            $display("FAIL inval_refill: got reads=%0d idx=%0d dat=%h expected 4 10 %h",
                     obs_en_cnt, obs_ack_idx, obs_ack_dat, WA);
        end
    endtask

    task automatic test_inval_fill();
        run_txn(1'b0, 32'h3800_0028, 4'hF, 32'h0, 16, -1, 2);
        checks++;
        if ((obs_en_cnt != 4) || (obs_ack_idx != 10) || (obs_ack_dat !== WG)) begin
            errors++;
            $display("FAIL inval_fill_ack: got reads=%0d idx=%0d dat=%h expected 4 10 %h",
                     obs_en_cnt, obs_ack_idx, obs_ack_dat, WG);
        end
        run_txn(1'b0, 32'h3800_002C, 4'hF, 32'h0, 16, -1, -1);
        checks++;
        if ((obs_en_cnt != 4) || (obs_ack_idx != 10) || (obs_ack_dat !== WH)) begin
            errors++;
            $display("FAIL inval_fill_line: got reads=%0d idx=%0d dat=%h expected 4 10 %h",
                     obs_en_cnt, obs_ack_idx, obs_ack_dat, WH);
        end
    endtask

    task automatic test_window();
        run_txn(1'b0, 32'h3000_0000, 4'hF, 32'h0, 20, -1, -1);
        checks++;
        if ((obs_ack_cnt != 0) || (obs_en_cnt != 0) || (obs_quiet_bad != 0)) begin
            errors++;
            $display("FAIL window_ignore: got acks=%0d reads=%0d quiet=%0d expected 0 0 0",
                     obs_ack_cnt, obs_en_cnt, obs_quiet_bad);
        end
    endtask

    task automatic test_cyc_drop();
        run_txn(1'b0, 32'h3800_0004, 4'hF, 32'h0, 16, 3, -1);
        checks++;
        if ((obs_ack_cnt != 0) || (obs_en_cnt != 4)) begin
            errors++;
            $display("FAIL drop_fill: got acks=%0d reads=%0d expected 0 4",
                     obs_ack_cnt, obs_en_cnt);
        end
        run_txn(1'b0, 32'h3800_0008, 4'hF, 32'h0, 6, -1, -1);
        checks++;
        if ((obs_ack_idx != 1) || (obs_en_cnt != 0) || (obs_ack_dat !== WK)) begin
            errors++;
            $display("FAIL drop_then_hit: got idx=%0d reads=%0d dat=%h expected 1 0 %h",
                     obs_ack_idx, obs_en_cnt, obs_ack_dat, WK);
        end
    endtask

    task automatic test_write_miss();
        run_txn(1'b1, 32'h3800_0034, 4'hF, 32'h5555_6666, 16, -1, -1);
        checks++;
        if ((obs_en_cnt != 1) || (obs_ack_idx != 10) || (mem[13] !== 32'h5555_6666)) begin
            errors++;
            $display("FAIL wr_miss: got writes=%0d idx=%0d mem=%h expected 1 10 %h",
                     obs_en_cnt, obs_ack_idx, mem[13], 32'h5555_6666);
        end
        run_txn(1'b0, 32'h3800_0004, 4'hF, 32'h0, 6, -1, -1);
        checks++;
        if ((obs_ack_idx != 1) || (obs_en_cnt != 0) || (obs_ack_dat !== WJ)) begin
            errors++;
            $display("FAIL wr_miss_buf: got idx=%0d reads=%0d dat=%h expected 1 0 %h",
                     obs_ack_idx, obs_en_cnt, obs_ack_dat, WJ);
        end
    endtask

    initial begin
        test_reset();
        test_reset_mid();
        test_cold_read();
        test_hit_read();
        test_write();
        test_inval();
        test_inval_fill();
        test_window();
        test_cyc_drop();
        test_write_miss();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
